// File: rtl/stream_fifo_pkg.sv
// Shared sizing helpers and handshake-event encoding for the stream FIFO.
package stream_fifo_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    PUSH = 2'd1,
    POP  = 2'd2,
    BOTH = 2'd3
  } hs_event_e;

  function automatic int ptr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Storage array for the stream FIFO: one synchronous write port, one asynchronous read port.
module stream_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int PTR_W      = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PTR_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Per-entry decode keeps writes inside the array when DEPTH is not a power of two.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (we && (waddr == PTR_W'(gi))) begin
        mem[gi] <= wdata;
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready FIFO over a circular buffer: pointers, fill level, flush and status flags.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic [DATA_WIDTH-1:0]      dataIn,
  input  logic                       dataInValid,
  output logic                       dataInReady,
  output logic [DATA_WIDTH-1:0]      dataOut,
  output logic                       dataOutValid,
  input  logic                       dataOutReady,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almostFull,
  output logic                       almostEmpty
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int LVL_W = lvl_w(DEPTH);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AF_LVL   = LVL_W'(AF_LEVEL);
  localparam logic [LVL_W-1:0] AE_LVL   = LVL_W'(AE_LEVEL);

  if (DEPTH < 2) begin : g_bad_depth
    $error("stream_fifo: DEPTH must be at least 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("stream_fifo: AF_LEVEL must lie in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("stream_fifo: AE_LEVEL must lie in 0..DEPTH-1");
  end

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0] level_reg, level_next;
  logic             full, empty;
  logic             push, pop;
  logic             clear;
  hs_event_e        hs_event;

  // Flags come from the registered level only, so ready never depends on dataOutReady.
  assign full  = (level_reg == FULL_LVL);
  assign empty = (level_reg == '0);
  assign push  = dataInValid && !full;
  assign pop   = dataOutReady && !empty;
  assign clear = !resetn || flush;

  assign dataInReady  = !full;
  assign dataOutValid = !empty;
  assign level        = level_reg;
  assign almostFull   = (level_reg >= AF_LVL);
  assign almostEmpty  = (level_reg <= AE_LVL);

  always_comb begin
    hs_event    = NONE;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;

    case ({push, pop})
      2'b10:   hs_event = PUSH;
      2'b01:   hs_event = POP;
      2'b11:   hs_event = BOTH;
      default: hs_event = NONE;
    endcase

    if (push) begin
      wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
    end

    case (hs_event)
      PUSH:    level_next = level_reg + LVL_W'(1);
      POP:     level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase

    // Reset and flush both discard everything, including this cycle's handshakes.
    if (clear) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_reg <= wr_ptr_next;
    rd_ptr_reg <= rd_ptr_next;
    level_reg  <= level_next;
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (level_reg <= FULL_LVL)
        else $error("stream_fifo: level above DEPTH");
      assert (!(hs_event == POP && level_reg == '0))
        else $error("stream_fifo: pop from empty");
      assert (!(hs_event == PUSH && full))
        else $error("stream_fifo: push into full");
    end
  end

  stream_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push && !clear),
    .waddr (wr_ptr_reg),
    .wdata (dataIn),
    .raddr (rd_ptr_reg),
    .rdata (dataOut)
  );

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench: directed vectors on a DEPTH=8 FIFO, random traffic on a DEPTH=5 FIFO.
module tb_stream_fifo;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // DEPTH=8, DATA_WIDTH=32 instance (AF_LEVEL=6, AE_LEVEL=1)
  logic        f8, v8, r8, ir8, ov8, af8, ae8;
  logic [31:0] d8, do8;
  logic [3:0]  lv8;

  // DEPTH=5, DATA_WIDTH=16 instance (AF_LEVEL=3, AE_LEVEL=1)
  logic        f5, v5, r5, ir5, ov5, af5, ae5;
  logic [15:0] d5, do5;
  logic [2:0]  lv5;

  stream_fifo #(.DATA_WIDTH(32), .DEPTH(8)) u_fifo8 (
    .clk(clk), .resetn(resetn), .flush(f8),
    .dataIn(d8), .dataInValid(v8), .dataInReady(ir8),
    .dataOut(do8), .dataOutValid(ov8), .dataOutReady(r8),
    .level(lv8), .almostFull(af8), .almostEmpty(ae8)
  );

  stream_fifo #(.DATA_WIDTH(16), .DEPTH(5)) u_fifo5 (
    .clk(clk), .resetn(resetn), .flush(f5),
    .dataIn(d5), .dataInValid(v5), .dataInReady(ir5),
    .dataOut(do5), .dataOutValid(ov5), .dataOutReady(r5),
    .level(lv5), .almostFull(af5), .almostEmpty(ae5)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        iv;
    logic [31:0] din;
    logic        ordy;
    logic        fl;
    int          lvl;
    logic        ir;
    logic        ov;
    logic [31:0] dout;
    logic        af;
    logic        ae;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push8(input logic [31:0] data);
    v8 = 1'b1; d8 = data; r8 = 1'b0;
    step();
    v8 = 1'b0;
  endtask

  task automatic idle8();
    v8 = 1'b0; r8 = 1'b0; f8 = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   q5[$];
    int   lvl_model;
    logic p, o;

    resetn = 1'b0;
    idle8();
    d8 = '0;
    f5 = 1'b0; v5 = 1'b0; r5 = 1'b0; d5 = '0;
    @(negedge clk);
    step();
    step();
    resetn = 1'b1;

    // Reset state
    check("rst_level", lv8, 0);
    check("rst_in_ready", ir8, 1);
    check("rst_out_valid", ov8, 0);
    check("rst_af", af8, 0);
    check("rst_ae", ae8, 1);
    check("rst_level5", lv5, 0);
    $display("reset: level=%0d in_ready=%0b out_valid=%0b", lv8, ir8, ov8);

    // Fill 0x1..0x8 plus a rejected 9th, then drain in order.
    for (int k = 1; k <= 9; k++) begin
      v.iv = 1'b1; v.din = k; v.ordy = 1'b0; v.fl = 1'b0;
      v.lvl = (k > 8) ? 8 : k;
      v.ir = (k < 8); v.ov = 1'b1; v.dout = 32'h1;
      v.af = (v.lvl >= 6); v.ae = (v.lvl <= 1);
      vecs.push_back(v);
    end
    for (int j = 1; j <= 8; j++) begin
      v.iv = 1'b0; v.din = 32'hDEAD; v.ordy = 1'b1; v.fl = 1'b0;
      v.lvl = 8 - j;
      v.ir = 1'b1; v.ov = (j < 8); v.dout = j + 1;
      v.af = (v.lvl >= 6); v.ae = (v.lvl <= 1);
      vecs.push_back(v);
    end

    foreach (vecs[i]) begin
      v8 = vecs[i].iv; d8 = vecs[i].din; r8 = vecs[i].ordy; f8 = vecs[i].fl;
      step();
      check($sformatf("vec%0d_level", i), lv8, vecs[i].lvl);
      check($sformatf("vec%0d_in_ready", i), ir8, vecs[i].ir);
      check($sformatf("vec%0d_out_valid", i), ov8, vecs[i].ov);
      check($sformatf("vec%0d_af", i), af8, vecs[i].af);
      check($sformatf("vec%0d_ae", i), ae8, vecs[i].ae);
      if (vecs[i].ov) check($sformatf("vec%0d_data", i), do8, vecs[i].dout);
      $display("vec %0d: in_valid=%0b data=0x%0h out_ready=%0b -> level=%0d out=0x%0h",
               i, vecs[i].iv, vecs[i].din, vecs[i].ordy, lv8, do8);
    end
    idle8();

    // Simultaneous push/pop at level 3 across several pointer wraps.
    for (int k = 0; k < 3; k++) push8(100 + k);
    check("pp_level_start", lv8, 3);
    for (int i = 0; i < 20; i++) begin
      check("pp_out_valid", ov8, 1);
      check("pp_head", do8, 100 + i);
      v8 = 1'b1; d8 = 103 + i; r8 = 1'b1;
      step();
      check("pp_level", lv8, 3);
      $display("push/pop %0d: popped 0x%0h pushed 0x%0h level=%0d", i, 100 + i, 103 + i, lv8);
    end
    v8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("pp_tail", do8, 120 + k);
      r8 = 1'b1;
      step();
    end
    r8 = 1'b0;
    check("pp_level_end", lv8, 0);

    // Full plus pop: first cycle only pops, second cycle pushes and pops.
    for (int k = 0; k < 8; k++) push8(200 + k);
    check("fp_level_full", lv8, 8);
    v8 = 1'b1; d8 = 208; r8 = 1'b1;
    check("fp_in_ready_full", ir8, 0);
    step();
    check("fp_c1_level", lv8, 7);
    check("fp_c1_head", do8, 201);
    step();
    check("fp_c2_level", lv8, 7);
    check("fp_c2_head", do8, 202);
    $display("full+pop: level=%0d head=0x%0h", lv8, do8);
    v8 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check("fp_drain", do8, 202 + k);
      step();
    end
    r8 = 1'b0;
    check("fp_level_end", lv8, 0);

    // Flush at level 5 while push and pop are requested.
    for (int k = 0; k < 5; k++) push8(32'h50 + k);
    check("fl_level5", lv8, 5);
    v8 = 1'b1; d8 = 32'h99; r8 = 1'b1; f8 = 1'b1;
    step();
    idle8();
    check("fl_level", lv8, 0);
    check("fl_out_valid", ov8, 0);
    check("fl_in_ready", ir8, 1);
    v8 = 1'b1; d8 = 32'hAA;
    check("fl_no_bypass", ov8, 0);
    step();
    v8 = 1'b0;
    check("fl_aa_valid", ov8, 1);
    check("fl_aa_data", do8, 32'hAA);
    check("fl_aa_level", lv8, 1);
    $display("flush: then push 0xAA -> out=0x%0h level=%0d", do8, lv8);
    r8 = 1'b1;
    step();
    r8 = 1'b0;
    check("fl_pop_level", lv8, 0);

    // Reset mid-operation discards contents.
    for (int k = 0; k < 3; k++) push8(32'h70 + k);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("rm_level", lv8, 0);
    check("rm_out_valid", ov8, 0);
    push8(32'h33);
    check("rm_head", do8, 32'h33);
    $display("mid reset: push 0x33 -> out=0x%0h level=%0d", do8, lv8);
    r8 = 1'b1;
    step();
    r8 = 1'b0;

    // Random traffic on DEPTH=5 against a queue scoreboard.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      lvl_model = q5.size();
      check("rnd_level", lv5, lvl_model);
      check("rnd_in_ready", ir5, (lvl_model < 5));
      check("rnd_out_valid", ov5, (lvl_model > 0));
      check("rnd_af", af5, (lvl_model >= 3));
      check("rnd_ae", ae5, (lvl_model <= 1));
      if (lvl_model > 0) check("rnd_data", do5, q5[0]);

      if (((cyc / 300) % 2) == 0) begin
        v5 = ($urandom_range(0, 99) < 70);
        r5 = ($urandom_range(0, 99) < 35);
      end else begin
        v5 = ($urandom_range(0, 99) < 35);
        r5 = ($urandom_range(0, 99) < 70);
      end
      d5 = 16'($urandom);
      f5 = ($urandom_range(0, 255) == 0);

      if (f5) begin
        q5.delete();
      end else begin
        p = v5 && (lvl_model < 5);
        o = r5 && (lvl_model > 0);
        if (o) void'(q5.pop_front());
        if (p) q5.push_back(int'(d5));
      end
      step();
      if ((cyc % 1000) == 999) $display("random: %0d cycles, level=%0d", cyc + 1, lv5);
    end
    f5 = 1'b0; v5 = 1'b0; r5 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Parametrised valid/ready stream FIFO built on a circular buffer with read/write pointers, replacing shift-register queues in the streaming datapath. Supports any depth ≥ 2, first-word-fall-through output, simultaneous push and pop, synchronous flush, and fill-level/threshold status for upstream throttling. Sits between any two AXI4-Stream-style valid/ready stages.

## Interface
- DATA_WIDTH, 32, payload width in bits (≥ 1)
- DEPTH, 8, entry count (≥ 2; need not be a power of two)
- AF_LEVEL, DEPTH-2, almostFull asserts when level ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almostEmpty asserts when level ≤ AE_LEVEL (0..DEPTH-1)

Ports:
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  reset, synchronous, active-low
- flush  in  1  synchronous discard of all contents
- dataIn  in  DATA_WIDTH  upstream payload
- dataInValid  in  1  upstream has data
- dataInReady  out  1  FIFO can accept (= !full)
- dataOut  out  DATA_WIDTH  head entry (FWFT)
- dataOutValid  out  1  head entry valid (= !empty)
- dataOutReady  in  1  downstream accepts
- level  out  $clog2(DEPTH+1)  current entry count
- almostFull  out  1  level ≥ AF_LEVEL
- almostEmpty  out  1  level ≤ AE_LEVEL

## Operation
- push = dataInValid && dataInReady; pop = dataOutValid && dataOutReady.
- push: mem[wrPtr] ← dataIn; wrPtr advances.
- pop: rdPtr advances.
- wrPtr and rdPtr range 0..DEPTH-1 and wrap to 0 after DEPTH-1; explicit compare, not power-of-two masking.
- level' = level + push - pop; never exceeds DEPTH and never goes below 0 (guaranteed by the handshake; assertions in RTL).
- full = (level == DEPTH); empty = (level == 0). Derive both from the registered level only.
- dataInReady does not depend on dataOutReady. At full, a simultaneous pop does not allow a push in the same cycle, so there is no combinational ready path.
- Push and pop together when 0 < level < DEPTH: both take effect and level is unchanged.
- Push into an empty FIFO: the entry appears on dataOut with dataOutValid = 1 one cycle later. There is no same-cycle bypass.
- dataOut = mem[rdPtr] (asynchronous read). Its value is don't-care while dataOutValid = 0.
- flush (resetn high): pointers and level go to 0 next cycle. Any push or pop in the flush cycle is ignored. mem contents are unchanged.
- Reset mid-operation behaves identically to flush. In-flight data is lost.
- No state machine is needed: the pointers plus level fully define state. The status flags are combinational from level.

## Timing
- Reset values: dataInReady = 1, dataOutValid = 0, level = 0, almostFull = (AF_LEVEL == 0 ? 1 : 0) → 0 for legal params, almostEmpty = 1. dataOut is undefined.
- Write-to-read latency: 1 cycle.
- Throughput: 1 push + 1 pop per cycle sustained whenever 0 < level < DEPTH.
- Status outputs update the cycle after the handshake edge.
- Elaboration checks: $error if DEPTH < 2, if AF_LEVEL is outside 1..DEPTH, or if AE_LEVEL is outside 0..DEPTH-1.

## Structure
- Package stream_fifo_pkg:
  - function ptr_w(depth) = max(1, $clog2(depth))
  - function lvl_w(depth) = $clog2(depth+1)
  - typedef for handshake-event enum {NONE, PUSH, POP, BOTH}, used in the level update case
- Sub-module stream_fifo_mem: DEPTH×DATA_WIDTH register array with one synchronous write port and one asynchronous read port. It contains no reset on storage.
- Top stream_fifo holds the pointers, level, flush/reset logic and flags. Target is about 150–250 lines total.

## Test plan
- Reset, then fill with DEPTH=8, DATA_WIDTH=32: push 0x1..0x8 with dataOutReady=0 → level 8, dataInReady=0, almostFull asserted from level 6; a 9th push is not accepted.
- Drain: dataOutReady=1 after the fill → dataOut 0x1..0x8 in order, one per cycle. dataOutValid drops after the 8th; almostEmpty asserts at level 1.
- Simultaneous push/pop at level 3 for 20 cycles with incrementing data → level stays 3 and order is preserved across pointer wrap (≥ 2 wraps).
- Full plus pop: at level 8 drive dataInValid=1 and dataOutReady=1 → cycle 1 pops only (level 7); cycle 2 push and pop (level 7).
- Flush at level 5 with push and pop asserted → next cycle level 0, dataOutValid=0, and the next push of 0xAA appears as dataOut 0xAA.
- Non-power-of-two DEPTH=5: random valid/ready for 10k cycles against a scoreboard queue → no mismatch and no level > 5.
